// File: rtl/dds_seq_pkg.sv
// Shared definitions for the AD9959 table player, the AXI register block and the profile RAM.
// Keeps the default address/data widths and the player state encoding in one place.
package dds_seq_pkg;

    localparam int DDS_ADDR_W = 12;
    localparam int DDS_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        OUT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/dds_seq_player.sv
// Trigger-stepped profile table player: each trigger fetches one word of the address window
// from the profile RAM read port and offers it on a valid/ready stream.
module dds_seq_player
    import dds_seq_pkg::*;
#(
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [ADDR_W-1:0] cfg_end_addr,
    input  logic              cfg_loop,
    input  logic              cmd_arm,
    input  logic              cmd_abort,
    input  logic              trig,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              trig_overrun
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] start_addr_q;
    logic [ADDR_W-1:0] end_addr_q;
    logic              loop_q;
    logic              bram_en_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic              done_q;
    logic              overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            loop_q       <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cmd_abort) begin
                // Abort outranks everything, including a simultaneous arm.
                state_q   <= IDLE;
                bram_en_q <= 1'b0;
                m_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_arm) begin
                            start_addr_q <= cfg_start_addr;
                            end_addr_q   <= cfg_end_addr;
                            loop_q       <= cfg_loop;
                            cur_addr_q   <= cfg_start_addr;
                            overrun_q    <= 1'b0;
                            state_q      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (trig) begin
                            bram_en_q   <= 1'b1;
                            bram_addr_q <= cur_addr_q;
                            state_q     <= FETCH;
                        end
                    end
                    FETCH: begin
                        bram_en_q <= 1'b0;
                        if (trig) overrun_q <= 1'b1;
                        state_q <= LOAD;
                    end
                    LOAD: begin
                        m_data_q  <= bram_dout;
                        m_valid_q <= 1'b1;
                        if (trig) overrun_q <= 1'b1;
                        state_q <= OUT;
                    end
                    OUT: begin
                        if (trig) overrun_q <= 1'b1;
                        if (m_ready) begin
                            m_valid_q <= 1'b0;
                            if (cur_addr_q == end_addr_q) begin
                                if (loop_q) begin
                                    cur_addr_q <= start_addr_q;
                                    state_q    <= WAIT;
                                end else begin
                                    done_q  <= 1'b1;
                                    state_q <= IDLE;
                                end
                            end else begin
                                // Wraps through the top of the RAM when end < start.
                                cur_addr_q <= cur_addr_q + ADDR_W'(1);
                                state_q    <= WAIT;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bram_en      = bram_en_q;
    assign bram_addr    = bram_addr_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign done         = done_q;
    assign trig_overrun = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dds_seq_player.sv
// Directed bench for dds_seq_player with a behavioural profile RAM holding 0xA000_0000 + address.
// Table-driven sequences plus hand-written backpressure, abort, collision and reset cases.
module tb_dds_seq_player;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_start_addr;
    logic [AW-1:0] cfg_end_addr;
    logic          cfg_loop;
    logic          cmd_arm;
    logic          cmd_abort;
    logic          trig;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic          trig_overrun;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [4096];

    dds_seq_player #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start_addr (cfg_start_addr),
        .cfg_end_addr   (cfg_end_addr),
        .cfg_loop       (cfg_loop),
        .cmd_arm        (cmd_arm),
        .cmd_abort      (cmd_abort),
        .trig           (trig),
        .bram_en        (bram_en),
        .bram_addr      (bram_addr),
        .bram_dout      (bram_dout),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .trig_overrun   (trig_overrun)
    );

    always #5 clk = ~clk;

    // Registered-read RAM port: data appears the cycle after bram_en.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
    end

    typedef struct packed {
        logic [AW-1:0]      start_a;
        logic [AW-1:0]      end_a;
        logic               loop;
        logic [3:0]         ntrig;
        logic [5:0][AW-1:0] exp_addr;
        logic               exp_done;
    } vec_t;

    vec_t vecs [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic arm(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic lp);
        cfg_start_addr = s;
        cfg_end_addr   = e;
        cfg_loop       = lp;
        cmd_arm        = 1'b1;
        tick();
        cmd_arm        = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + i;

        // start, end, loop, trigs, expected addresses [5..0], done expected
        vecs[0] = '{start_a: 12'h002, end_a: 12'h004, loop: 1'b0, ntrig: 4'd3,
                    exp_addr: {12'h000, 12'h000, 12'h000, 12'h004, 12'h003, 12'h002},
                    exp_done: 1'b1};
        vecs[1] = '{start_a: 12'hFFE, end_a: 12'h001, loop: 1'b1, ntrig: 4'd6,
                    exp_addr: {12'hFFF, 12'hFFE, 12'h001, 12'h000, 12'hFFF, 12'hFFE},
                    exp_done: 1'b0};
        vecs[2] = '{start_a: 12'h007, end_a: 12'h007, loop: 1'b0, ntrig: 4'd1,
                    exp_addr: {12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h007},
                    exp_done: 1'b1};

        rst = 1'b1; cfg_start_addr = '0; cfg_end_addr = '0; cfg_loop = 1'b0;
        cmd_arm = 1'b0; cmd_abort = 1'b0; trig = 1'b0; m_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", m_data, 32'd0);
        chk("reset_bram_en", 32'(bram_en), 32'd0);
        chk("reset_overrun", 32'(trig_overrun), 32'd0);

        for (int v = 0; v < 3; v++) begin
            arm(vecs[v].start_a, vecs[v].end_a, vecs[v].loop);
            chk("arm_busy", 32'(busy), 32'd1);
            for (int s = 0; s < int'(vecs[v].ntrig); s++) begin
                logic last;
                last = (s == int'(vecs[v].ntrig) - 1);
                trig = 1'b1;
                tick();
                trig = 1'b0;
                chk("fetch_en", 32'(bram_en), 32'd1);
                chk("fetch_addr", 32'(bram_addr), 32'(vecs[v].exp_addr[s]));
                tick();
                chk("load_valid", 32'(m_valid), 32'd0);
                tick();
                chk("out_valid", 32'(m_valid), 32'd1);
                chk("out_data", m_data, 32'hA000_0000 + 32'(vecs[v].exp_addr[s]));
                $display("vec %0d step %0d addr=%h data=%h", v, s, vecs[v].exp_addr[s], m_data);
                tick();
                chk("post_done", 32'(done), 32'(last && vecs[v].exp_done));
                chk("post_busy", 32'(busy), 32'(!(last && vecs[v].exp_done)));
                chk("post_valid", 32'(m_valid), 32'd0);
            end
            if (!vecs[v].exp_done) begin
                cmd_abort = 1'b1;
                tick();
                cmd_abort = 1'b0;
                chk("loop_abort_busy", 32'(busy), 32'd0);
                chk("loop_abort_done", 32'(done), 32'd0);
            end
            tick();
        end

        // Backpressure: ten cycles of m_ready low, one trigger in the window.
        arm(12'd10, 12'd12, 1'b0);
        m_ready = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_data", m_data, 32'hA000_000A);
            trig = (i == 3);
            tick();
        end
        trig = 1'b0;
        chk("bp_overrun", 32'(trig_overrun), 32'd1);
        m_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(m_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd1);
        $display("backpressure word data=%h overrun=%0d", m_data, trig_overrun);
        for (int i = 0; i < 4; i++) begin
            chk("bp_no_extra_en", 32'(bram_en), 32'd0);
            chk("bp_no_extra_valid", 32'(m_valid), 32'd0);
            tick();
        end

        // Abort while in LOAD, then re-arm at a new start.
        trig = 1'b1; tick(); trig = 1'b0;
        chk("ab_fetch_addr", 32'(bram_addr), 32'd11);
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(m_valid), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_overrun_sticky", 32'(trig_overrun), 32'd1);
        tick();
        chk("ab_done_later", 32'(done), 32'd0);
        chk("ab_valid_later", 32'(m_valid), 32'd0);
        $display("abort in LOAD busy=%0d m_valid=%0d", busy, m_valid);
        arm(12'd20, 12'd20, 1'b0);
        chk("rearm_overrun", 32'(trig_overrun), 32'd0);
        chk("rearm_busy", 32'(busy), 32'd1);
        trig = 1'b1; tick(); trig = 1'b0;
        chk("rearm_addr", 32'(bram_addr), 32'd20);
        tick(); tick();
        chk("rearm_data", m_data, 32'hA000_0014);
        tick();
        chk("rearm_done", 32'(done), 32'd1);
        tick();
        chk("rearm_done_pulse", 32'(done), 32'd0);

        // Arm and abort together in IDLE: abort wins.
        cfg_start_addr = 12'd1; cfg_end_addr = 12'd2; cfg_loop = 1'b0;
        cmd_arm = 1'b1; cmd_abort = 1'b1;
        tick();
        cmd_arm = 1'b0; cmd_abort = 1'b0;
        chk("coll_busy", 32'(busy), 32'd0);
        tick();
        chk("coll_busy_later", 32'(busy), 32'd0);
        $display("arm+abort collision busy=%0d", busy);

        // Reset while a word is held in OUT.
        arm(12'd5, 12'd6, 1'b0);
        m_ready = 1'b0;
        trig = 1'b1; tick();
        tick();
        trig = 1'b0;
        tick();
        chk("rst_pre_valid", 32'(m_valid), 32'd1);
        chk("rst_pre_overrun", 32'(trig_overrun), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(trig_overrun), 32'd0);
        $display("reset in OUT busy=%0d m_data=%h", busy, m_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_seq_player.md
# dds_seq_player

Trigger-stepped table player for the AD9959 DDS controller. Walks a user-defined address window of the dual-port profile RAM through its read-only port, one entry per trigger. Each fetched word is presented on a valid/ready stream to the downstream SPI command serializer. The RAM's write port stays with the AXI register side; this block is the sole owner of the read port.

## Interface
Parameters:
- ADDR_W, 12, profile RAM address width
- DATA_W, 32, profile RAM word width

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  single clock; also drives the RAM read-port clock
- rst  in  1  synchronous, active-high reset
- cfg_start_addr  in  ADDR_W  first table entry; latched on arm
- cfg_end_addr  in  ADDR_W  last table entry; latched on arm
- cfg_loop  in  1  1 = restart at start after end; latched on arm
- cmd_arm  in  1  single-cycle pulse; starts a sequence from IDLE
- cmd_abort  in  1  single-cycle pulse; returns to IDLE from any state
- trig  in  1  synchronous step trigger; level sampled each cycle
- bram_en  out  1  RAM read-port enable
- bram_addr  out  ADDR_W  RAM read-port address
- bram_dout  in  DATA_W  RAM read data; 1-cycle registered latency after bram_en
- m_valid  out  1  stream word valid
- m_data  out  DATA_W  stream word
- m_ready  in  1  downstream accept
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a non-looping sequence completes
- trig_overrun  out  1  sticky; a trigger arrived while a step was in flight; cleared by arm or rst

## Operation
States:
- IDLE: on cmd_arm, latch cfg_*, set cur_addr = start, clear trig_overrun, go to WAIT.
- WAIT: on trig, go to FETCH.
- FETCH: drive bram_en=1 and bram_addr=cur_addr for exactly one cycle, then go to LOAD.
- LOAD: on the next edge, capture bram_dout into m_data, set m_valid=1, go to OUT.
- OUT: hold m_valid and m_data stable until m_valid&&m_ready, then:
  - cur_addr == end, loop=0: pulse done, go to IDLE.
  - cur_addr == end, loop=1: cur_addr = start, go to WAIT.
  - otherwise: cur_addr = cur_addr+1 (mod 2^ADDR_W), go to WAIT.

Rules:
- Address wrap: increment is modulo 2^ADDR_W. end < start therefore plays through the top of the RAM and wraps to 0. start == end gives a one-entry table.
- trig in FETCH, LOAD or OUT: the trigger is ignored and trig_overrun is set. Triggers are never queued.
- cmd_arm outside IDLE is ignored; config changes outside IDLE have no effect.
- cmd_abort: takes effect on the next edge from any state. Next state is IDLE, m_valid=0, bram_en=0, and any in-flight word is dropped with no done pulse. When cmd_abort and cmd_arm are asserted together, abort wins.
- Reset values: state IDLE; bram_en 0; bram_addr 0; m_valid 0; m_data 0; busy 0; done 0; trig_overrun 0; cur_addr 0.

## Timing
- trig high in WAIT at cycle t:
  - cycle t+1: FETCH (bram_en=1).
  - cycle t+2: LOAD (bram_dout valid).
  - cycle t+3: m_valid=1; earliest handshake.
- Handshake at cycle k: next state WAIT from k+1, so a trig at k+1 is accepted. The minimum step period is 4 cycles with m_ready held high.
- done is high in the cycle after the final handshake; busy is 0 in that same cycle.
- busy rises the cycle after cmd_arm.
- m_data changes only on the LOAD→OUT edge.

## Structure
- Shared package dds_seq_pkg holds:
  - state enum: IDLE, WAIT, FETCH, LOAD, OUT.
  - default ADDR_W/DATA_W constants shared with the AXI register block and the RAM instance.
- Single flat module, no sub-modules. The profile RAM is instantiated by the parent; this block only connects to its read port.

## Test plan
- Basic sequence:
  - Stimulus: preload RAM[i]=0xA000_0000+i; arm with start=2, end=4, loop=0; 3 trigs, m_ready=1.
  - Required: m_data 0xA0000002, 0xA0000003, 0xA0000004, each m_valid exactly 3 cycles after its trig; done pulses once; busy 0.
- Looping and wrap:
  - Stimulus: ADDR_W=12, start=0xFFE, end=0x001, loop=1; 6 trigs.
  - Required: addresses 0xFFE, 0xFFF, 0x000, 0x001, 0xFFE, 0xFFF; no done.
- Backpressure:
  - Stimulus: m_ready low for 10 cycles after m_valid rises.
  - Required: m_data stable, m_valid held; a trig during that window sets trig_overrun and causes no extra word.
- Abort mid-step:
  - Stimulus: cmd_abort in LOAD.
  - Required: next cycle IDLE, m_valid 0, no done. A following arm restarts at the new start and clears trig_overrun.
- Collisions and reset:
  - Stimulus: cmd_arm with cmd_abort together in IDLE.
  - Required: remains IDLE.
  - Stimulus: rst during OUT.
  - Required: all outputs at their reset values next cycle.
- Single entry:
  - Stimulus: start=end=7, loop=0, 1 trig.
  - Required: one word RAM[7], done one cycle after the handshake.
